// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//   UART transmitter, companion of the RX deserializer. A parallel word is
//   accepted on DATA_VALID while idle and sent LSB first as
//   start / WIDTH data bits / optional parity / stop. Every bit is held for
//   PRESCALE CLK cycles, so TX and RX share CLK and the PRESCALE setting.
//
// Ports
//   CLK         in   1               system / oversampling clock, rising edge
//   RST         in   1               asynchronous reset, active low
//   P_DATA      in   WIDTH           parallel word to send
//   DATA_VALID  in   1               request strobe, sampled only while idle
//   PAR_EN      in   1               1 = insert a parity bit
//   PAR_TYP     in   1               0 = even parity, 1 = odd parity
//   PRESCALE    in   PRESCALE_WIDTH  CLK cycles per bit (0 behaves as 1)
//   TX_OUT      out  1               serial line, registered, idles high
//   BUSY        out  1               high while a frame is on the line
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH-1:0]          P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [3:0]                LAST_BIT = 4'(WIDTH - 1);
  localparam logic [PRESCALE_WIDTH-1:0] ONE_CNT  = PRESCALE_WIDTH'(1);

  state_t                    state_reg;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_reg;
  logic [PRESCALE_WIDTH-1:0] last_edge_reg;  // latched PRESCALE-1
  logic [3:0]                bit_cnt_reg;
  logic [WIDTH-1:0]          data_reg;       // shifts right as bits go out
  logic                      par_en_reg;
  logic                      parity_reg;
  logic                      tx_out_reg;
  logic                      busy_reg;
  logic                      bit_done;

  // The current bit ends on the cycle its edge counter reaches PRESCALE-1.
  assign bit_done = (edge_cnt_reg == last_edge_reg);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= S_IDLE;
      edge_cnt_reg  <= '0;
      last_edge_reg <= '0;
      bit_cnt_reg   <= '0;
      data_reg      <= '0;
      par_en_reg    <= 1'b0;
      parity_reg    <= 1'b0;
      tx_out_reg    <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      // Edge counter runs in every non-idle state and wraps at bit end.
      if (state_reg != S_IDLE) begin
        if (bit_done) begin
          edge_cnt_reg <= '0;
        end else begin
          edge_cnt_reg <= edge_cnt_reg + ONE_CNT;
        end
      end

      case (state_reg)
        S_IDLE: begin
          tx_out_reg   <= 1'b1;
          busy_reg     <= 1'b0;
          edge_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
          if (DATA_VALID) begin
            data_reg   <= P_DATA;
            par_en_reg <= PAR_EN;
            parity_reg <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            // PRESCALE of 0 is folded onto 1 so the wrap compare is never
            // against an underflowed value.
            last_edge_reg <= (PRESCALE == '0) ? '0 : (PRESCALE - ONE_CNT);
            // Start bit goes on the line at the accepting edge itself.
            state_reg  <= S_START;
            tx_out_reg <= 1'b0;
            busy_reg   <= 1'b1;
          end
        end

        S_START: begin
          if (bit_done) begin
            tx_out_reg  <= data_reg[0];
            data_reg    <= data_reg >> 1;
            bit_cnt_reg <= '0;
            state_reg   <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_done) begin
            if (bit_cnt_reg == LAST_BIT) begin
              if (par_en_reg) begin
                tx_out_reg <= parity_reg;
                state_reg  <= S_PARITY;
              end else begin
                tx_out_reg <= 1'b1;
                state_reg  <= S_STOP;
              end
            end else begin
              // data_reg[0] now holds original bit bit_cnt_reg+1.
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              tx_out_reg  <= data_reg[0];
              data_reg    <= data_reg >> 1;
            end
          end
        end

        S_PARITY: begin
          if (bit_done) begin
            tx_out_reg <= 1'b1;
            state_reg  <= S_STOP;
          end
        end

        S_STOP: begin
          if (bit_done) begin
            tx_out_reg <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= S_IDLE;
          end
        end

        default: begin
          tx_out_reg <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= S_IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = tx_out_reg;
  assign BUSY   = busy_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//   Drives frames into uart_tx_serializer and compares TX_OUT / BUSY on every
//   cycle against the frame the bench builds from the data, parity settings
//   and prescale it requested.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int W  = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [W-1:0]  P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [PW-1:0] PRESCALE = '0;
  logic          TX_OUT;
  logic          BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_serializer #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference frame: bit j of the serial frame for the given settings.
  function automatic logic frame_bit(input logic [W-1:0] d, input bit pe, input bit pt, input int j);
    int ones;
    ones = $countones(d);
    if (j == 0) return 1'b0;
    if (j <= W) return d[j-1];
    if (pe && j == W + 1) return logic'((ones % 2) ^ int'(pt));
    return 1'b1;
  endfunction

  // Called at posedge+1. Requests a frame, then checks every cycle of it plus
  // the idle cycle that follows. noise scrambles inputs mid-frame; hold keeps
  // DATA_VALID asserted for the whole frame.
  task automatic send_frame(input logic [W-1:0] d, input bit pe, input bit pt,
                            input int presc, input bit noise, input bit hold);
    int p;
    int total;
    int errs_before;
    p = (presc == 0) ? 1 : presc;
    total = (W + 2 + int'(pe)) * p;
    errs_before = n_checks - n_pass;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; PRESCALE = PW'(presc); DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = hold;
    for (int k = 0; k < total; k++) begin
      check("tx_bit", TX_OUT, frame_bit(d, pe, pt, k / p));
      check("busy_hi", BUSY, 1'b1);
      if (noise) begin
        P_DATA = W'($urandom);
        PRESCALE = PW'($urandom);
        PAR_EN = 1'($urandom);
        PAR_TYP = 1'($urandom);
        DATA_VALID = 1'($urandom);
      end
      @(posedge CLK); #1;
    end
    check("end_busy", BUSY, 1'b0);
    check("end_tx", TX_OUT, 1'b1);
    DATA_VALID = 1'b0;
    $display("frame data=%02h par_en=%0d par_typ=%0d prescale=%0d noise=%0d hold=%0d cycles=%0d errors=%0d",
             d, pe, pt, presc, noise, hold, total, (n_checks - n_pass) - errs_before);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      check("idle_tx", TX_OUT, 1'b1);
      check("idle_busy", BUSY, 1'b0);
    end
  endtask

  // Abort a 0xF7 frame (bit 3 = 0) during data bit 3 with an async reset.
  task automatic reset_mid_frame(input int p);
    P_DATA = 8'hF7; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = PW'(p); DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    repeat (4 * p + 1) begin
      @(posedge CLK); #1;
    end
    check("pre_rst_tx", TX_OUT, 1'b0);
    check("pre_rst_busy", BUSY, 1'b1);
    RST = 1'b0;
    #1;
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    idle_cycles(6);
    $display("reset abort during data bit 3, prescale=%0d", p);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_tx", TX_OUT, 1'b1);
    check("reset_busy", BUSY, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    idle_cycles(3);

    // Directed frames.
    send_frame(8'hA5, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    idle_cycles(2);
    send_frame(8'hA5, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    idle_cycles(2);
    send_frame(8'hA5, 1'b1, 1'b1, 8, 1'b0, 1'b0);
    idle_cycles(2);
    send_frame(8'h07, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    idle_cycles(2);
    send_frame(8'h3C, 1'b0, 1'b0, 4, 1'b1, 1'b0);
    idle_cycles(3);
    // Back-to-back with DATA_VALID held: one idle cycle between frames.
    send_frame(8'h55, 1'b0, 1'b0, 16, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b0, 16, 1'b0, 1'b1);
    idle_cycles(2);
    // PRESCALE of 0 behaves as 1.
    send_frame(8'h96, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    idle_cycles(2);
    reset_mid_frame(8);
    send_frame(8'h81, 1'b1, 1'b0, 3, 1'b0, 1'b0);
    idle_cycles(1);

    // Randomized frames.
    for (int i = 0; i < 24; i++) begin
      send_frame(W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
